// File: rtl/ram_stream_reader.sv
// rtl/ram_stream_reader.sv - burst reader from a synchronous RAM into a ready/valid stream
module ram_stream_reader #(
  parameter int Dw = 32,
  parameter int Aw = 10
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic [Aw-1:0] start_addr,
  input  logic [Aw:0]   length,
  output logic          busy,
  output logic          done,
  output logic          rd_en,
  output logic [Aw-1:0] rd_addr,
  input  logic [Dw-1:0] rd_q,
  output logic [Dw-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_last
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_nx;
  logic [Aw:0]   remaining;
  logic [Aw-1:0] addr;
  logic          inflight;
  logic          inflight_last;
  logic [Dw-1:0] fifo_data [2];
  logic          fifo_last [2];
  logic          wr_ptr, rd_ptr;
  logic [1:0]    fifo_count;
  logic [2:0]    occupancy;
  logic          pop;

  assign out_valid = (fifo_count != 2'd0);
  assign out_data  = fifo_data[rd_ptr];
  assign out_last  = out_valid & fifo_last[rd_ptr];
  assign pop       = out_valid & out_ready;
  assign rd_addr   = addr;

  // Words already buffered plus the one arriving next cycle, net of this cycle's pop.
  // A pop implies fifo_count >= 1, so this never underflows.
  assign occupancy = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  // Next-state and control outputs; a read is issued only when the 2-entry FIFO cannot overflow
  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    rd_en    = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nx = (length == '0) ? DONE : RUN;
      end
      RUN: begin
        busy  = 1'b1;
        rd_en = (remaining != '0) && (occupancy < 3'd2);
        if (pop && out_last) state_nx = DONE;
      end
      DONE: begin
        busy     = 1'b1;
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Read-side bookkeeping: burst capture in IDLE, address/word count advance per issued read
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr          <= '0;
      remaining     <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        addr      <= start_addr;
        remaining <= length;
      end else if (rd_en) begin
        addr      <= addr + {{(Aw-1){1'b0}}, 1'b1};
        remaining <= remaining - {{Aw{1'b0}}, 1'b1};
      end
      inflight      <= rd_en;
      inflight_last <= rd_en && (remaining == {{Aw{1'b0}}, 1'b1});
    end
  end

  // Output FIFO: capture RAM data the cycle after each read, drain on handshake
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) begin
        fifo_data[i] <= '0;
        fifo_last[i] <= 1'b0;
      end
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      fifo_count <= 2'd0;
    end else begin
      if (inflight) begin
        fifo_data[wr_ptr] <= rd_q;
        fifo_last[wr_ptr] <= inflight_last;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      fifo_count <= fifo_count + {1'b0, inflight} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_ram_stream_reader.sv
// tb/tb_ram_stream_reader.sv - directed self-checking bench for ram_stream_reader
module tb_ram_stream_reader;

  localparam int Dw = 32;
  localparam int Aw = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          start = 1'b0;
  logic [Aw-1:0] start_addr = '0;
  logic [Aw:0]   length = '0;
  logic          busy, done, rd_en, out_valid, out_last;
  logic          out_ready = 1'b0;
  logic [Aw-1:0] rd_addr;
  logic [Dw-1:0] rd_q = '0;
  logic [Dw-1:0] out_data;

  int checks = 0;
  int errors = 0;

  ram_stream_reader #(.Dw(Dw), .Aw(Aw)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .start_addr(start_addr),
    .length(length), .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_q(rd_q), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ram_val(input int i);
    return 32'hBEEF_0000 + i * 32'h0000_0101;
  endfunction

  // Synchronous RAM read port: data one cycle after rd_en
  always @(posedge clk) if (rd_en) rd_q <= ram_val(int'(rd_addr));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run_basic();
    @(posedge clk); #1;
    start = 1'b1; start_addr = 4'd5; length = 5'd4; out_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      #1;
      check($sformatf("basic_rd_en_c%0d", k), rd_en, (k <= 4));
      if (k <= 4) check($sformatf("basic_rd_addr_c%0d", k), rd_addr, 4 + k);
      check($sformatf("basic_valid_c%0d", k), out_valid, (k >= 3 && k <= 6));
      if (k >= 3 && k <= 6) check($sformatf("basic_data_c%0d", k), out_data, ram_val(k + 2));
      check($sformatf("basic_last_c%0d", k), out_last, (k == 6));
      check($sformatf("basic_done_c%0d", k), done, (k == 7));
      check($sformatf("basic_busy_c%0d", k), busy, (k <= 7));
    end
  endtask

  task automatic run_burst(input int sa, input int len, input bit stall, input bit restart);
    logic [15:0] pat = 16'b1011_0010_0110_1101;
    int n = 0;
    int outstanding = 0;
    bit pv = 0, pr = 0, seen_done = 0;
    logic [31:0] pd = '0;
    logic pp;
    @(posedge clk); #1;
    start = 1'b1; start_addr = sa[Aw-1:0]; length = len[Aw:0]; out_ready = 1'b1;
    for (int cyc = 1; cyc <= 200 && !seen_done; cyc++) begin
      @(posedge clk); #1;
      start = (restart && cyc == 4);
      if (restart && cyc == 4) begin
        start_addr = 4'd0; length = 5'd2;
      end
      out_ready = !stall ? 1'b1 : (cyc <= 10) ? 1'b0 : pat[cyc % 16];
      #1;
      pp = out_valid && out_ready;
      if (rd_en) check("gate_fifo_room", (outstanding - int'(pp)) < 2, 1'b1);
      if (pv && !pr) begin
        check("stall_valid_hold", out_valid, 1'b1);
        check("stall_data_hold", out_data, pd);
      end
      if (pp) begin
        check($sformatf("beat%0d_data", n), out_data, ram_val((sa + n) % 16));
        check($sformatf("beat%0d_last", n), out_last, (n == len - 1));
        n++;
      end
      if (done) begin
        seen_done = 1;
        check("done_beat_count", n, len);
      end
      outstanding = outstanding + int'(rd_en) - int'(pp);
      pv = out_valid; pr = out_ready; pd = out_data;
    end
    check("burst_done_seen", seen_done, 1'b1);
    start = 1'b0;
    @(posedge clk); #2;
    check("burst_idle_after", busy, 1'b0);
    check("burst_no_residual", out_valid, 1'b0);
  endtask

  initial begin
    #2 reset_n = 1'b0;
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_rd_en", rd_en, 1'b0);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_valid", out_valid, 1'b0);
    check("rst_last", out_last, 1'b0);
    check("rst_data", out_data, 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    run_basic();
    run_burst(14, 4, 1'b0, 1'b0);
    run_burst(3, 16, 1'b0, 1'b0);
    run_burst(9, 8, 1'b1, 1'b1);

    // Zero-length burst
    @(posedge clk); #1;
    start = 1'b1; start_addr = 4'd7; length = 5'd0;
    @(posedge clk); #1;
    start = 1'b0; #1;
    check("zero_done_c1", done, 1'b1);
    check("zero_busy_c1", busy, 1'b1);
    check("zero_rd_en_c1", rd_en, 1'b0);
    check("zero_valid_c1", out_valid, 1'b0);
    @(posedge clk); #2;
    check("zero_done_c2", done, 1'b0);
    check("zero_busy_c2", busy, 1'b0);
    check("zero_rd_en_c2", rd_en, 1'b0);

    // Reset mid-burst after two beats
    @(posedge clk); #1;
    start = 1'b1; start_addr = 4'd5; length = 5'd8; out_ready = 1'b1;
    begin
      int beats = 0;
      for (int c = 0; c < 20 && beats < 2; c++) begin
        @(posedge clk); #1;
        start = 1'b0; #1;
        if (out_valid && out_ready) beats++;
      end
      check("mid_two_beats", beats, 2);
    end
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_done", done, 1'b0);
    check("mid_rst_rd_en", rd_en, 1'b0);
    check("mid_rst_rd_addr", rd_addr, 0);
    check("mid_rst_valid", out_valid, 1'b0);
    check("mid_rst_last", out_last, 1'b0);
    check("mid_rst_data", out_data, 0);
    @(posedge clk); #1 reset_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #2;
      check("post_rst_valid", out_valid, 1'b0);
      check("post_rst_done", done, 1'b0);
      check("post_rst_busy", busy, 1'b0);
    end
    run_basic();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
